fetch_unit: RTL and testbench

- Instruction-fetch initiator for the instruction memory. It owns the PC, issues word-aligned read requests, collects in-order responses and buffers them in a small prefetch FIFO.
- Hands {pc, instruction} pairs to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered instructions and discarding stale in-flight responses.

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 100 ++++++++++
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared constants and the prefetch-buffer entry type used by
//               the instruction fetch unit and its prefetch FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  // Instruction and address width of the fetch path.
  localparam int c_INSTR_W = 32;

  // Byte distance between consecutive sequential fetches.
  localparam int c_PC_STEP = 4;

  // Default PC loaded on reset.
  localparam logic [c_INSTR_W-1:0] c_RESET_PC = 32'h0000_0000;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [c_INSTR_W-1:0] pc;
    logic [c_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous prefetch FIFO of fetch_entry_t. The head entry is
//               held in a register so the consumer sees flop outputs. Flush
//               has priority over push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output fetch_entry_t           head
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

  fetch_entry_t        r_mem [DEPTH];
  fetch_entry_t        r_head;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_CNT_W-1:0]  r_count;

  logic                w_do_push;
  logic                w_do_pop;
  logic [c_PTR_W-1:0]  w_rd_ptr_inc;
  logic [c_CNT_W-1:0]  w_count_after_pop;

  assign full  = (r_count == c_DEPTH_CNT);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_head;

  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands
  // when the same cycle also frees the head slot.
  assign w_do_pop          = pop && !empty;
  assign w_do_push         = push && (!full || w_do_pop);
  assign w_rd_ptr_inc      = r_rd_ptr + c_PTR_W'(1);
  assign w_count_after_pop = r_count - c_CNT_W'(w_do_pop);

  // Storage array: written at the tail, never reset (contents gated by count).
  always_ff @(posedge clk) begin
    if (w_do_push && !flush) begin
      r_mem[r_wr_ptr] <= push_entry;
    end
  end

  // Pointers, occupancy and the registered head entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      r_count <= w_count_after_pop + c_CNT_W'(w_do_push);
      // The next head is the following stored entry, or the incoming one
      // when the FIFO would otherwise run empty.
      if (w_do_pop) begin
        if (w_count_after_pop != '0) begin
          r_head <= r_mem[w_rd_ptr_inc];
        end else if (w_do_push) begin
          r_head <= push_entry;
        end
      end else if (empty && w_do_push) begin
        r_head <= push_entry;
      end
    end
  end

`ifndef SYNTHESIS
  // Upstream credit accounting guarantees a free slot for every push.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop && !flush));
`endif

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch initiator. Owns the PC, issues word-aligned
//               reads with a bounded number in flight, reserves a prefetch
//               slot per live request, and hands {pc, instr} to decode over
//               valid/ready. Redirects flush the buffer and discard stale
//               in-flight responses.
//               Optional build macro FETCH_MISALIGN_TRAP_EN: adds the
//               fetch_misaligned output and stalls fetch after a redirect to
//               an unaligned PC; without it redirect_pc[1:0] is forced to 00.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                     DATA_WIDTH      = c_INSTR_W,
  parameter logic [DATA_WIDTH-1:0]  RESET_PC        = DATA_WIDTH'(c_RESET_PC),
  parameter int                     FIFO_DEPTH      = 4,
  parameter int                     MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [DATA_WIDTH-1:0] imem_addr,
  input  logic                  imem_gnt,
  input  logic                  imem_rvalid,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic                  fetch_misaligned
`endif
);

  localparam int c_OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int c_SUM_W = ((c_CNT_W > c_OUT_W) ? c_CNT_W : c_OUT_W) + 1;
  localparam logic [c_OUT_W-1:0]    c_OUT_MAX   = c_OUT_W'(MAX_OUTSTANDING);
  localparam logic [c_SUM_W-1:0]    c_SUM_DEPTH = c_SUM_W'(FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] c_STEP      = DATA_WIDTH'(c_PC_STEP);

  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_resp_pc;
  logic [c_OUT_W-1:0]    r_outstanding;
  logic [c_OUT_W-1:0]    r_drop;

  logic [c_OUT_W-1:0]    w_outstanding_nxt;
  logic [c_SUM_W-1:0]    w_reserved;
  logic [c_CNT_W-1:0]    w_fifo_count;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_req;
  logic                  w_grant;
  logic                  w_live_resp;
  logic                  w_pop;
  logic                  w_trap;
  logic                  w_unused;
  logic [DATA_WIDTH-1:0] w_redirect_pc;
  fetch_entry_t          w_push_entry;
  fetch_entry_t          w_head;

  // Slots already spoken for: buffered entries plus live (non-stale) requests.
  assign w_reserved = c_SUM_W'(w_fifo_count) + c_SUM_W'(r_outstanding)
                    - c_SUM_W'(r_drop);

  assign w_req = !reset && !redirect && !w_trap
              && (r_outstanding < c_OUT_MAX)
              && (w_reserved < c_SUM_DEPTH);

  assign w_grant     = w_req && imem_gnt;
  // A response arriving during a redirect belongs to the old stream.
  assign w_live_resp = imem_rvalid && (r_drop == '0) && !redirect;
  assign w_pop       = instr_valid && instr_ready && !redirect;

  assign w_outstanding_nxt = r_outstanding + c_OUT_W'(w_grant)
                           - c_OUT_W'(imem_rvalid);

  assign imem_req  = w_req;
  assign imem_addr = r_pc;

  assign w_push_entry.pc    = c_INSTR_W'(r_resp_pc);
  assign w_push_entry.instr = c_INSTR_W'(imem_rdata);

  assign instr_valid = !w_fifo_empty;
  assign instr       = DATA_WIDTH'(w_head.instr);
  assign instr_pc    = DATA_WIDTH'(w_head.pc);

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misaligned;

  // Trap flag follows the alignment of the most recent redirect target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_misaligned <= 1'b0;
    end else if (redirect) begin
      r_misaligned <= (redirect_pc[1:0] != 2'b00);
    end
  end

  assign fetch_misaligned = r_misaligned;
  assign w_trap           = r_misaligned;
  assign w_redirect_pc    = redirect_pc;
  assign w_unused         = w_fifo_full;
`else
  assign w_trap        = 1'b0;
  assign w_redirect_pc = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
  assign w_unused      = w_fifo_full ^ (^redirect_pc[1:0]);
`endif

  // Fetch PC, response PC tracking, in-flight and stale-response counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop        <= '0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      if (redirect) begin
        // Everything still unanswered after this cycle is stale.
        r_pc      <= w_redirect_pc;
        r_resp_pc <= w_redirect_pc;
        r_drop    <= w_outstanding_nxt;
      end else begin
        if (w_grant) begin
          r_pc <= r_pc + c_STEP;
        end
        if (w_live_resp) begin
          r_resp_pc <= r_resp_pc + c_STEP;
        end
        if (imem_rvalid && (r_drop != '0)) begin
          r_drop <= r_drop - c_OUT_W'(1);
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (reset),
    .push       (w_live_resp),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .flush      (redirect),
    .full       (w_fifo_full),
    .empty      (w_fifo_empty),
    .count      (w_fifo_count),
    .head       (w_head)
  );

`ifndef SYNTHESIS
  a_outstanding_max : assert property (@(posedge clk) disable iff (reset)
    r_outstanding <= c_OUT_MAX);
  a_drop_bounded : assert property (@(posedge clk) disable iff (reset)
    r_drop <= r_outstanding);
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Scoreboard bench for fetch_unit with a small in-order
//               instruction memory model and directed phases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  logic        clk         = 1'b0;
  logic        rst         = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt    = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = 32'h0;
  logic        redirect    = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  fetch_unit #(
    .DATA_WIDTH      (32),
    .RESET_PC        (32'h0000_0000),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory image: a fixed word derived from the address.
  function automatic logic [31:0] img(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  typedef struct { int due; logic [31:0] addr; } pend_t;
  pend_t pend_q[$];
  int    mem_lat  = 1;
  bit    gnt_pat  = 1'b0;
  int    n_grants = 0;
  int    max_pend = 0;

  always @(negedge clk) begin
    imem_rvalid = 1'b0;
    if (rst) begin
      pend_q.delete();
      imem_gnt = 1'b0;
    end else begin
      imem_gnt = gnt_pat ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = img(pend_q[0].addr);
        void'(pend_q.pop_front());
      end
      if (imem_req && imem_gnt) begin
        pend_q.push_back('{due: cyc + mem_lat, addr: imem_addr});
        n_grants++;
        if (pend_q.size() > max_pend) max_pend = pend_q.size();
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  logic [31:0] exp_q[$];
  int n_acc           = 0;
  int first_valid_cyc = -1;

  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (instr_valid && instr_ready && !redirect) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got pc=%h instr=%h, required no output", instr_pc, instr);
        end else begin
          e = exp_q.pop_front();
          check("sb_out", {instr_pc, instr}, {e, img(e)});
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  int rel_cyc = 0;
  int g0      = 0;
  int acc0    = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] base);
    for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("rst_req",   {63'h0, imem_req},    64'h0);
    check("rst_addr",  {32'h0, imem_addr},   64'h0);
    check("rst_valid", {63'h0, instr_valid}, 64'h0);
    check("rst_instr", {32'h0, instr},       64'h0);
    check("rst_pc",    {32'h0, instr_pc},    64'h0);
    @(posedge clk);
    #1;
    rst             = 1'b0;
    rel_cyc         = cyc;
    first_valid_cyc = -1;
    g0              = n_grants;
    acc0            = n_acc;
    max_pend        = 0;
  endtask

  task automatic wait_acc(input int target, input int bound, input string name);
    int start;
    int k;
    start = n_acc;
    k     = 0;
    while ((n_acc - start) < target && k < bound) begin
      tick();
      k++;
    end
    n_checks++;
    if ((n_acc - start) < target) begin
      n_fail++;
      $display("FAIL %s: accepted %0d, required %0d", name, n_acc - start, target);
    end
  endtask

  // Redirect for one cycle; the expected stream is replaced at the same time.
  task automatic do_redirect(input logic [31:0] target, input logic [31:0] exp_base, input bit expect_out);
    redirect    = 1'b1;
    redirect_pc = target;
    exp_q.delete();
    if (expect_out) push_exp(exp_base);
    @(negedge clk);
    check("redir_req_low", {63'h0, imem_req}, 64'h0);
    @(posedge clk);
    #1;
    redirect = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed phases ----------------
  initial begin
    int k;
    repeat (2) tick();

    // Zero-wait memory, decode always ready.
    instr_ready = 1'b1;
    mem_lat     = 1;
    gnt_pat     = 1'b0;
    apply_reset();
    push_exp(32'h0);
    repeat (22) tick();
    check("first_valid_latency", 64'(first_valid_cyc - rel_cyc), 64'd2);
    check("throughput_20cyc",    64'(n_acc - acc0),             64'd20);

    // Decode stalled: FIFO fills, requests stop at four reserved slots.
    instr_ready = 1'b0;
    apply_reset();
    repeat (10) tick();
    check("stall_grants", 64'(n_grants - g0), 64'd4);
    @(negedge clk);
    check("stall_req_low", {63'h0, imem_req},    64'h0);
    check("stall_valid",   {63'h0, instr_valid}, 64'h1);
    check("stall_head",    {instr_pc, instr},    {32'h0, img(32'h0)});
    @(posedge clk);
    #1;
    push_exp(32'h0);
    instr_ready = 1'b1;
    wait_acc(16, 100, "stall_resume");

    // Slow memory with bursty grants, then redirect with requests in flight.
    apply_reset();
    mem_lat = 3;
    gnt_pat = 1'b1;
    push_exp(32'h0);
    wait_acc(12, 300, "slow_mem_stream");
    k = 0;
    while (pend_q.size() != 2 && k < 50) begin
      tick();
      k++;
    end
    check("two_in_flight", 64'(pend_q.size()), 64'd2);
    do_redirect(32'h100, 32'h100, 1'b1);
    wait_acc(12, 300, "after_redirect_100");
    check("outstanding_max", 64'(max_pend), 64'd2);

    // Zero-wait steady stream, redirect coinciding with a response.
    mem_lat = 1;
    gnt_pat = 1'b0;
    repeat (10) tick();
    do_redirect(32'h400, 32'h400, 1'b1);
    @(negedge clk);
    check("n1_addr",  {32'h0, imem_addr},   {32'h0, 32'h400});
    check("n1_req",   {63'h0, imem_req},    64'h1);
    check("n1_valid", {63'h0, instr_valid}, 64'h0);
    @(posedge clk);
    #1;
    wait_acc(8, 100, "after_redirect_400");

`ifdef FETCH_MISALIGN_TRAP_EN
    do_redirect(32'h102, 32'h0, 1'b0);
    @(negedge clk);
    check("mis_flag_set", {63'h0, fetch_misaligned}, 64'h1);
    check("mis_req_low",  {63'h0, imem_req},         64'h0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mis_req_held", {63'h0, imem_req},    64'h0);
    check("mis_valid",    {63'h0, instr_valid}, 64'h0);
    @(posedge clk);
    #1;
    do_redirect(32'h200, 32'h200, 1'b1);
    @(negedge clk);
    check("mis_flag_clr", {63'h0, fetch_misaligned}, 64'h0);
    check("mis_resume_req",  {63'h0, imem_req},  64'h1);
    check("mis_resume_addr", {32'h0, imem_addr}, {32'h0, 32'h200});
    @(posedge clk);
    #1;
    wait_acc(8, 100, "after_redirect_200");
`else
    do_redirect(32'h302, 32'h300, 1'b1);
    @(negedge clk);
    check("align_addr", {32'h0, imem_addr}, {32'h0, 32'h300});
    check("align_req",  {63'h0, imem_req},  64'h1);
    @(posedge clk);
    #1;
    wait_acc(8, 100, "after_redirect_300");
`endif

    instr_ready = 1'b0;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
